mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store access controller between the single-cycle MIPS datapath and the word-organised data memory. Converts CPU byte-addressed load/store requests of byte, halfword or word size into word accesses on the memory port. Performs sign/zero extension on loads, and read-modify-write on sub-word stores. Flags misaligned or illegal accesses and suppresses their memory writes; stalls the datapath one cycle per sub-word store.

## Interface
Parameters:
- ADDR_SIZE, 16, word-address bits used by the data memory; byte address bits [ADDR_SIZE+1:2] select the word.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cpu_addr  in  32  byte address from ALU
- cpu_wdata  in  32  store data; sub-word data right-justified
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- cpu_unsigned  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- cpu_rdata  out  32  extended load result
- stall  out  1  hold PC and pipeline inputs this cycle
- misaligned  out  1  access is misaligned or reserved size; combinational
- mem_addr  out  32  word-aligned address to memory ([1:0] = 00)
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data from memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, sampled on rising clk

## Operation
- Byte order big-endian: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00, or size 11 while read or write asserted. Result: misaligned=1, mem_read=mem_write=0, stall=0, cpu_rdata=0.
- Load: mem_read=1, mem_addr = {cpu_addr[31:2],2'b00}. cpu_rdata = selected lane, sign- or zero-extended per cpu_unsigned; word loads ignore cpu_unsigned.
- Word store: single cycle, mem_write=1, mem_wdata=cpu_wdata, stall=0.
- Sub-word store, FSM IDLE -> MERGE -> IDLE:
  - IDLE, sub-word store seen: stall=1, mem_read=1, mem_write=0. On the clock edge, register mem_rdata, word address, lane offset, size and cpu_wdata[15:0]; go to MERGE.
  - MERGE: stall=0, mem_write=1, mem_addr = registered address, mem_wdata = registered word with target lane(s) replaced by registered data. Return to IDLE unconditionally.
  - MERGE uses only registered values; CPU inputs in that cycle are ignored for the write. CPU keeps the request stable during the stall cycle (datapath contract).
- cpu_read and cpu_write both high: treated as a store; cpu_rdata=0.
- Neither asserted: all memory enables 0, stall=0, cpu_rdata=0.
- Reset: state=IDLE, all capture registers 0. While rst=1, stall, mem_read and mem_write are forced 0. Reset in MERGE aborts the write: no memory update.

## Timing
- Loads: zero added latency; cpu_rdata combinational from mem_rdata in the same cycle.
- Word store: 1 cycle, written at the edge ending the request cycle.
- Sub-word store: 2 cycles; stall high exactly in cycle 1; memory updated at the edge ending cycle 2.
- misaligned is valid combinationally in the request cycle; never registered.
- Back-to-back sub-word stores: every store gets its own IDLE->MERGE pair, never overlapped.

## Structure
- Shared package/header: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state constants (ST_IDLE, ST_MERGE).
- One natural sub-module, `lane_merge`: combinational insertion of byte/halfword into a word by offset. The load extractor stays inline.

## Test plan
- Reset: hold rst 2 cycles -> stall=0, mem_write=0, state IDLE; rst released with no request -> all enables 0.
- Loads, memory word 0x8001_7F02 at 0x10: lb 0x10 -> 0xFFFF_FF80; lbu 0x10 -> 0x0000_0080; lh 0x12 -> 0x0000_7F02; lhu 0x10 -> 0x0000_8001; lw 0x10 -> 0x8001_7F02; all same cycle, stall=0.
- sb 0xAB to 0x21, memory word 0x1122_3344 -> stall one cycle, then mem_write with 0x11AB_3344; memory reads 0x11AB_3344.
- sh 0xBEEF to 0x22 immediately followed by sb 0x55 to 0x20 on the same word 0x0000_0000 -> 0x0000_BEEF, then 0x5500_BEEF; 4 cycles total, 2 stall cycles.
- Misaligned: lw 0x13, sh 0x15, size 11 -> misaligned=1, no memory change, cpu_rdata=0, stall=0.
- rst asserted during MERGE of sb 0xFF to 0x30 -> memory word at 0x30 unchanged; next cycle state IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store access controller: access sizes,
// FSM states and the alignment rule shared by the datapath and merge logic.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  // Reserved size is treated as misaligned so it can never touch memory.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side and memory-side signal bundle of the access controller.
// The controller uses the slave view; the environment drives the master view.
interface mem_access_ctrl_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size, cpu_unsigned, mem_rdata,
    output cpu_rdata, stall, misaligned, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size, cpu_unsigned, mem_rdata,
    input  cpu_rdata, stall, misaligned, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_ctrl_lane_merge.sv
// Combinational insertion of a byte or halfword into a 32-bit word,
// big-endian lane numbering (offset 0 is the most significant lane).
module lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [15:0] data_in,
  input  logic [1:0]  offset,
  input  size_t       size,
  output logic [31:0] word_out
);

  // Replace the addressed lane(s); any other size leaves the word untouched.
  always_comb begin
    word_out = word_in;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'b00:   word_out = {data_in[7:0], word_in[23:0]};
          2'b01:   word_out = {word_in[31:24], data_in[7:0], word_in[15:0]};
          2'b10:   word_out = {word_in[31:16], data_in[7:0], word_in[7:0]};
          default: word_out = {word_in[31:8], data_in[7:0]};
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) begin
          word_out = {word_in[31:16], data_in};
        end else begin
          word_out = {data_in, word_in[15:0]};
        end
      end
      default: word_out = word_in;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: byte/half/word CPU accesses onto a word memory,
// with load extension and a two-cycle read-modify-write for sub-word stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  state_t                 state_q, state_d;
  logic [31:0]            word_q, word_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [1:0]             off_q, off_d;
  size_t                  size_q, size_d;
  logic [15:0]            data_q, data_d;

  size_t       req_size;
  logic        req_any;
  logic        bad_access;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;
  logic [31:0] merged_word;

  logic        stall_c;
  logic        mem_read_c;
  logic        mem_write_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic [31:0] cpu_rdata_c;

  assign req_size   = size_t'(bus.cpu_size);
  assign req_any    = bus.cpu_read | bus.cpu_write;
  assign bad_access = req_any & is_misaligned(req_size, bus.cpu_addr[1:0]);

  lane_merge u_lane_merge (
    .word_in  (word_q),
    .data_in  (data_q),
    .offset   (off_q),
    .size     (size_q),
    .word_out (merged_word)
  );

  // Load lane selection and sign/zero extension, straight from memory data.
  always_comb begin
    case (bus.cpu_addr[1:0])
      2'b00:   ld_byte = bus.mem_rdata[31:24];
      2'b01:   ld_byte = bus.mem_rdata[23:16];
      2'b10:   ld_byte = bus.mem_rdata[15:8];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    if (bus.cpu_addr[1]) begin
      ld_half = bus.mem_rdata[15:0];
    end else begin
      ld_half = bus.mem_rdata[31:16];
    end
    case (req_size)
      SZ_BYTE: ld_result = bus.cpu_unsigned ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_result = bus.cpu_unsigned ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      SZ_WORD: ld_result = bus.mem_rdata;
      default: ld_result = 32'h0000_0000;
    endcase
  end

  // Next-state, capture and memory-port control; MERGE ignores CPU inputs.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    data_d      = data_q;
    stall_c     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = {bus.cpu_addr[31:2], 2'b00};
    mem_wdata_c = 32'h0000_0000;
    cpu_rdata_c = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (bad_access) begin
          state_d = ST_IDLE;
        end else if (bus.cpu_write) begin
          if (req_size == SZ_WORD) begin
            mem_write_c = 1'b1;
            mem_wdata_c = bus.cpu_wdata;
          end else begin
            stall_c    = 1'b1;
            mem_read_c = 1'b1;
            word_d     = bus.mem_rdata;
            addr_d     = bus.cpu_addr[ADDR_SIZE+1:2];
            off_d      = bus.cpu_addr[1:0];
            size_d     = req_size;
            data_d     = bus.cpu_wdata[15:0];
            state_d    = ST_MERGE;
          end
        end else if (bus.cpu_read) begin
          mem_read_c  = 1'b1;
          cpu_rdata_c = ld_result;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
        mem_write_c = 1'b1;
        mem_addr_c  = 32'({addr_q, 2'b00});
        mem_wdata_c = merged_word;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= 32'h0000_0000;
      addr_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= SZ_BYTE;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

  // Reset masks every enable, which also aborts a pending MERGE write.
  assign bus.stall      = stall_c & ~rst;
  assign bus.mem_read   = mem_read_c & ~rst;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.misaligned = bad_access;

endmodule
